// File: rtl/wb_pkg.sv
//------------------------------------------------------------------
// wb_pkg: shared defaults and types for the write-back arbiter
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

package wb_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int NUM_REGS_DEF   = 32;
    localparam int STARVE_LIM_DEF = 3;

    // Which source feeds the output register this cycle
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_PRI  = 2'd1,
        SEL_FIFO = 2'd2
    } sel_e;

    // The starve counter must be able to hold the limit value itself
    function automatic int starve_w(input int lim);
        return (lim < 1) ? 1 : $clog2(lim + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
//------------------------------------------------------------------
// wb_fifo: secondary write-back queue exposing per-entry valid/addr
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module wb_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_W-1:0]            push_addr,
    input  logic [DATA_W-1:0]            push_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [ADDR_W-1:0]            head_addr,
    output logic [DATA_W-1:0]            head_data,
    output logic [DEPTH-1:0]             ent_valid,
    output logic [ADDR_W-1:0]            ent_addr [DEPTH]
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];

    // Explicit wrap so non-power-of-two depths work
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            if (pop) begin
                rd_ptr            <= ptr_inc(rd_ptr);
                ent_valid[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr            <= ptr_inc(wr_ptr);
                ent_valid[wr_ptr] <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= push_addr;
            mem_data[wr_ptr] <= push_data;
        end
    end

    assign head_addr = mem_addr[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign ent_addr[i] = mem_addr[i];
    end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
//------------------------------------------------------------------
// wb_arbiter: merges ALU and queued long-latency results onto the regfile port
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int ADDR_W     = $clog2(NUM_REGS),
    parameter int FIFO_DEPTH = 4,
    parameter int READ_PORTS = 2,
    parameter int STARVE_LIM = STARVE_LIM_DEF,
    parameter int DROP_R0    = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  p_valid,
    input  logic [ADDR_W-1:0]     p_addr,
    input  logic [DATA_W-1:0]     p_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [ADDR_W-1:0]     s_addr,
    input  logic [DATA_W-1:0]     s_data,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    input  logic [ADDR_W-1:0]     chk_addr [READ_PORTS],
    output logic [READ_PORTS-1:0] chk_pending,
    output logic                  stall_req,
    output logic                  wb_conflict
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SW    = starve_w(STARVE_LIM);

    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [FIFO_DEPTH-1:0] ent_valid;
    logic [ADDR_W-1:0] ent_addr [FIFO_DEPTH];
    logic              fifo_empty;
    logic              p_drop;
    logic              s_drop;
    logic              push;
    logic              pop;
    logic              p_hit;
    sel_e              sel;
    logic [SW-1:0]     starve;
    logic [SW-1:0]     starve_nxt;

    assign s_ready    = (count < CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign p_drop     = (DROP_R0 != 0) && (p_addr == '0);
    assign s_drop     = (DROP_R0 != 0) && (s_addr == '0);
    // A dropped secondary write still handshakes but never occupies a slot
    assign push       = s_valid && s_ready && !s_drop;
    assign pop        = (sel == SEL_FIFO);

    wb_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .pop       (pop),
        .push_addr (s_addr),
        .push_data (s_data),
        .count     (count),
        .head_addr (head_addr),
        .head_data (head_data),
        .ent_valid (ent_valid),
        .ent_addr  (ent_addr)
    );

    always_comb begin
        sel = SEL_NONE;
        if (p_valid)
            sel = SEL_PRI;
        else if (!fifo_empty)
            sel = SEL_FIFO;
    end

    always_comb begin
        p_hit = 1'b0;
        for (int j = 0; j < FIFO_DEPTH; j++)
            if (ent_valid[j] && (ent_addr[j] == p_addr))
                p_hit = 1'b1;
    end

    // Saturating count of consecutive cycles the queue head was denied
    always_comb begin
        starve_nxt = starve;
        if (fifo_empty || pop)
            starve_nxt = '0;
        else if (p_valid && (starve != SW'(STARVE_LIM)))
            starve_nxt = starve + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            case (sel)
                SEL_PRI: begin
                    wr_en   <= !p_drop;
                    wr_addr <= p_addr;
                    wr_data <= p_data;
                end
                SEL_FIFO: begin
                    wr_en   <= 1'b1;
                    wr_addr <= head_addr;
                    wr_data <= head_data;
                end
                default: wr_en <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve      <= '0;
            stall_req   <= 1'b0;
            wb_conflict <= 1'b0;
        end else begin
            starve    <= starve_nxt;
            stall_req <= (starve_nxt >= SW'(STARVE_LIM));
            if (p_valid && (p_hit || stall_req))
                wb_conflict <= 1'b1;
        end
    end

    for (genvar i = 0; i < READ_PORTS; i++) begin : g_chk
        logic hit;
        always_comb begin
            hit = wr_en && (wr_addr == chk_addr[i]);
            for (int j = 0; j < FIFO_DEPTH; j++)
                if (ent_valid[j] && (ent_addr[j] == chk_addr[i]))
                    hit = 1'b1;
        end
        assign chk_pending[i] = hit && !((DROP_R0 != 0) && (chk_addr[i] == '0));
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
//------------------------------------------------------------------
// tb_wb_arbiter: directed and randomized checks of wb_arbiter against a queue model
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module tb_wb_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int RP    = 2;
    localparam int LIM   = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic          p_valid;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data;
    logic          s_valid;
    logic          s_ready;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] chk_addr [RP];
    logic [RP-1:0] chk_pending;
    logic          stall_req;
    logic          wb_conflict;

    always #5 clk = ~clk;

    wb_arbiter #(
        .DATA_W     (DW),
        .NUM_REGS   (32),
        .FIFO_DEPTH (DEPTH),
        .READ_PORTS (RP),
        .STARVE_LIM (LIM),
        .DROP_R0    (1)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .p_valid     (p_valid),
        .p_addr      (p_addr),
        .p_data      (p_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_addr      (s_addr),
        .s_data      (s_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .chk_addr    (chk_addr),
        .chk_pending (chk_pending),
        .stall_req   (stall_req),
        .wb_conflict (wb_conflict)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    // Reference model: queue of outstanding secondary writes plus output state
    ent_t          mq[$];
    logic          m_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          m_stall;
    logic          m_conf;
    int            m_wait;

    int checks = 0;
    int errors = 0;

    task automatic idle();
        p_valid = 1'b0; p_addr = '0; p_data = '0;
        s_valid = 1'b0; s_addr = '0; s_data = '0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_en = 1'b0; m_addr = '0; m_data = '0;
        m_stall = 1'b0; m_conf = 1'b0; m_wait = 0;
    endtask

    function automatic bit in_q(input logic [AW-1:0] a);
        foreach (mq[k]) if (mq[k].a == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_pend(input logic [AW-1:0] a);
        return (a != '0) && (in_q(a) || (m_en && (m_addr == a)));
    endfunction

    // Advance the model by one clock using the current inputs, then clock the DUT
    task automatic step();
        bit   was_empty, popped, ready;
        ent_t h;
        ready     = (mq.size() < DEPTH);
        was_empty = (mq.size() == 0);
        popped    = 1'b0;
        if (p_valid && (in_q(p_addr) || m_stall)) m_conf = 1'b1;
        if (p_valid) begin
            m_en = (p_addr != '0); m_addr = p_addr; m_data = p_data;
        end else if (!was_empty) begin
            h = mq.pop_front();
            m_en = 1'b1; m_addr = h.a; m_data = h.d; popped = 1'b1;
        end else begin
            m_en = 1'b0;
        end
        if (was_empty || popped) m_wait = 0;
        else if (p_valid)        m_wait = m_wait + 1;
        m_stall = (m_wait >= LIM);
        if (s_valid && ready && (s_addr != '0))
            mq.push_back(ent_t'{a: s_addr, d: s_data});
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        idle();
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        chk_addr[0] = 5'd1; chk_addr[1] = 5'd2;
        #1;
        checks++;
        if ({wr_en, wr_addr, wr_data, s_ready, stall_req, wb_conflict, chk_pending} !==
            {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL reset_in: en=%b addr=%0d data=%h rdy=%b stall=%b conf=%b pend=%b exp 0/0/0/1/0/0/00",
                     wr_en, wr_addr, wr_data, s_ready, stall_req, wb_conflict, chk_pending);
        end
        release_reset();
        checks++;
        if ({wr_en, s_ready, stall_req, wb_conflict, chk_pending} !== {1'b0, 1'b1, 1'b0, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL reset_out: en=%b rdy=%b stall=%b conf=%b pend=%b exp 0/1/0/0/00",
                     wr_en, s_ready, stall_req, wb_conflict, chk_pending);
        end
    endtask

    task automatic test_primary();
        chk_addr[0] = 5'd5; chk_addr[1] = 5'd6;
        p_valid = 1'b1; p_addr = 5'd5; p_data = 32'hA5;
        #1;
        checks++;
        if (chk_pending !== 2'b00) begin
            errors++; $display("FAIL prim_same_cycle_pend: got %b exp 00", chk_pending);
        end
        step();
        checks++;
        if ({wr_en, wr_addr, wr_data, chk_pending} !== {1'b1, 5'd5, 32'hA5, 2'b01}) begin
            errors++;
            $display("FAIL prim_write: en=%b addr=%0d data=%h pend=%b exp 1/5/a5/01", wr_en, wr_addr, wr_data, chk_pending);
        end
        idle();
        step();
        checks++;
        if ({wr_en, wr_addr, wr_data, chk_pending} !== {1'b0, 5'd5, 32'hA5, 2'b00}) begin
            errors++;
            $display("FAIL prim_idle_hold: en=%b addr=%0d data=%h pend=%b exp 0/5/a5/00", wr_en, wr_addr, wr_data, chk_pending);
        end
    endtask

    task automatic test_fill();
        p_valid = 1'b1; p_addr = 5'd10; p_data = $urandom;
        for (int i = 1; i <= 4; i++) begin
            s_valid = 1'b1; s_addr = AW'(i); s_data = 32'h11 * i;
            step();
            checks++;
            if (s_ready !== (i < 4)) begin
                errors++; $display("FAIL fill_ready_%0d: got %b exp %b", i, s_ready, (i < 4));
            end
        end
        checks++;
        if (stall_req !== 1'b1) begin
            errors++; $display("FAIL fill_stall: got %b exp 1", stall_req);
        end
        idle();
        chk_addr[0] = 5'd3; chk_addr[1] = 5'd9;
        #1;
        checks++;
        if (chk_pending !== 2'b01) begin
            errors++; $display("FAIL fill_pend: got %b exp 01 (addr3=1 addr9=0)", chk_pending);
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if ({wr_en, wr_addr, wr_data} !== {1'b1, AW'(k), 32'h11 * k}) begin
                errors++;
                $display("FAIL fill_drain_%0d: en=%b addr=%0d data=%h exp 1/%0d/%h", k, wr_en, wr_addr, wr_data, k, 32'h11 * k);
            end
        end
        checks++;
        if ({s_ready, stall_req, wb_conflict} !== 3'b100) begin
            errors++; $display("FAIL fill_after: rdy=%b stall=%b conf=%b exp 1/0/0", s_ready, stall_req, wb_conflict);
        end
    endtask

    task automatic test_starve();
        s_valid = 1'b1; s_addr = 5'd2; s_data = 32'h22;
        step();
        s_valid = 1'b0;
        p_valid = 1'b1; p_addr = 5'd9; p_data = 32'h99;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (stall_req !== (k == 3)) begin
                errors++; $display("FAIL starve_stall_%0d: got %b exp %b", k, stall_req, (k == 3));
            end
        end
        idle();
        step();
        checks++;
        if ({wr_en, wr_addr, wr_data, stall_req} !== {1'b1, 5'd2, 32'h22, 1'b0}) begin
            errors++;
            $display("FAIL starve_pop: en=%b addr=%0d data=%h stall=%b exp 1/2/22/0", wr_en, wr_addr, wr_data, stall_req);
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] seq_a [8];
        logic          seq_p [8];
        logic [AW-1:0] got[$];
        seq_a = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd0, 5'd0};
        seq_p = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            p_valid = seq_p[i]; p_addr = 5'd20; p_data = 32'h2020;
            s_valid = (seq_a[i] != '0); s_addr = seq_a[i]; s_data = 32'h101 * seq_a[i];
            step();
            if (wr_en && (wr_addr != 5'd20)) got.push_back(wr_addr);
            if (i == 2) begin
                chk_addr[0] = 5'd3; chk_addr[1] = 5'd4;
                #1;
                checks++;
                if ({s_ready, chk_pending} !== 3'b101) begin
                    errors++; $display("FAIL wrap_pushpop: rdy=%b pend=%b exp 1/01", s_ready, chk_pending);
                end
            end
        end
        idle();
        checks++;
        if (got.size() != 6) begin
            errors++; $display("FAIL wrap_count: got %0d writes exp 6", got.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (got[k] !== AW'(k + 1)) begin
                    errors++; $display("FAIL wrap_order_%0d: got %0d exp %0d", k, got[k], k + 1);
                end
            end
        end
    endtask

    task automatic test_conflict();
        s_valid = 1'b1; s_addr = 5'd7; s_data = 32'h77;
        step();
        s_valid = 1'b0;
        p_valid = 1'b1; p_addr = 5'd7; p_data = 32'h1234;
        step();
        checks++;
        if ({wb_conflict, wr_en, wr_addr, wr_data} !== {1'b1, 1'b1, 5'd7, 32'h1234}) begin
            errors++;
            $display("FAIL conflict_set: conf=%b en=%b addr=%0d data=%h exp 1/1/7/1234", wb_conflict, wr_en, wr_addr, wr_data);
        end
        idle();
        repeat (3) step();
        checks++;
        if ({wb_conflict, s_ready, wr_en} !== 3'b110) begin
            errors++; $display("FAIL conflict_sticky: conf=%b rdy=%b en=%b exp 1/1/0", wb_conflict, s_ready, wr_en);
        end
        p_valid = 1'b1; p_addr = 5'd0; p_data = 32'hDEAD;
        s_valid = 1'b1; s_addr = 5'd0; s_data = 32'hBEEF;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL r0_handshake: rdy=%b exp 1", s_ready);
        end
        step();
        checks++;
        if (wr_en !== 1'b0) begin
            errors++; $display("FAIL r0_primary_drop: en=%b exp 0", wr_en);
        end
        idle();
        step();
        checks++;
        if (wr_en !== 1'b0) begin
            errors++; $display("FAIL r0_secondary_drop: en=%b exp 0", wr_en);
        end
    endtask

    task automatic test_reset_mid();
        p_valid = 1'b1; p_addr = 5'd11; p_data = 32'h1111;
        s_valid = 1'b1; s_addr = 5'd12; s_data = 32'h1212;
        step();
        s_addr = 5'd13;
        step();
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({wr_en, s_ready, stall_req, wb_conflict} !== 4'b0100) begin
            errors++;
            $display("FAIL midreset: en=%b rdy=%b stall=%b conf=%b exp 0/1/0/0", wr_en, s_ready, stall_req, wb_conflict);
        end
        release_reset();
        step();
        checks++;
        if ({wr_en, s_ready} !== 2'b01) begin
            errors++; $display("FAIL midreset_discard: en=%b rdy=%b exp 0/1", wr_en, s_ready);
        end
    endtask

    task automatic test_random();
        logic [42:0] obs, exp;
        bit          wild;
        for (int i = 0; i < 400; i++) begin
            wild = (i >= 200);
            for (int k = 0; k < RP; k++)
                chk_addr[k] = wild ? AW'($urandom % 8) : AW'($urandom % 32);
            #1;
            obs = {wr_en, wr_addr, wr_data, s_ready, stall_req, wb_conflict, chk_pending};
            exp = {m_en, m_addr, m_data, (mq.size() < DEPTH), m_stall, m_conf,
                   exp_pend(chk_addr[1]), exp_pend(chk_addr[0])};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random_cyc%0d: got en/addr/data/rdy/stall/conf/pend=%h exp %h", i, obs, exp);
            end
            if (m_stall)
                p_valid = wild && (($urandom % 10) == 0);
            else
                p_valid = (($urandom % 10) < 6);
            p_addr  = wild ? AW'($urandom % 8) : AW'(16 + ($urandom % 16));
            p_data  = $urandom;
            s_valid = (($urandom % 10) < 5);
            s_addr  = wild ? AW'($urandom % 8) : AW'($urandom % 16);
            s_data  = $urandom;
            step();
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        idle();
        model_reset();
        chk_addr[0] = '0;
        chk_addr[1] = '0;
        test_reset();
        test_primary();
        test_fill();
        test_starve();
        test_wrap();
        test_conflict();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Write-back stage that sits directly upstream of the CPU register file and drives its single synchronous write port (data_in/wraddr/wren).
- Merges two write-back sources:
  - Primary: the single-cycle ALU path. It has no backpressure and always wins arbitration.
  - Secondary: long-latency units such as load or multiply. These are buffered in a small FIFO.
- Exposes pending-write checks so decode can detect RAW hazards against writes not yet committed.
- Raises a stall request so secondary results cannot starve.

Parameters:
DATA_W, 32, register data width
NUM_REGS, 32, number of architectural registers
ADDR_W, $clog2(NUM_REGS), register address width
FIFO_DEPTH, 4, secondary queue entries (>=2, any integer)
READ_PORTS, 2, number of hazard-check ports
STARVE_LIM, 3, consecutive denied cycles before stall_req asserts
DROP_R0, 1, 1 = writes to address 0 are accepted and discarded

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
p_valid  in  1  primary write request
p_addr  in  ADDR_W  primary destination register
p_data  in  DATA_W  primary write data
s_valid  in  1  secondary write request
s_ready  out  1  secondary queue can accept
s_addr  in  ADDR_W  secondary destination register
s_data  in  DATA_W  secondary write data
wr_en  out  1  to regfile wren
wr_addr  out  ADDR_W  to regfile wraddr
wr_data  out  DATA_W  to regfile data_in
chk_addr  in  [READ_PORTS][ADDR_W]  hazard-check addresses
chk_pending  out  [READ_PORTS]  1 = uncommitted write to chk_addr exists
stall_req  out  1  pipeline must hold primary for one cycle
wb_conflict  out  1  sticky ordering-violation flag

Behaviour:
- Reset (async, rstn low):
  - wr_en, wr_addr, wr_data = 0; stall_req = 0; wb_conflict = 0.
  - FIFO count, read and write pointers = 0; starve counter = 0.
  - Therefore s_ready = 1.
- Output stage is registered, giving 1-cycle latency from request to wr_*. Data reaches the regfile array at the following edge.
- Selection, evaluated every cycle:
  - p_valid=1: wr_* <= primary.
  - Else, FIFO non-empty: wr_* <= FIFO head, and pop.
  - Else: wr_en <= 0. wr_addr/wr_data hold their previous values.
- Secondary handshake:
  - Push occurs when s_valid && s_ready.
  - s_ready = (count < FIFO_DEPTH). It depends on registered count only; a same-cycle pop does not free space.
  - With push and pop in the same cycle, count is unchanged and both pointers advance.
  - Pointers wrap from FIFO_DEPTH-1 to 0.
- DROP_R0=1:
  - A primary request with p_addr=0 produces wr_en=0.
  - A secondary push with s_addr=0 completes the handshake but stores nothing.
- Starvation:
  - The starve counter increments each cycle the FIFO is non-empty and p_valid=1.
  - It clears on any pop or when the FIFO is empty.
  - stall_req is registered. It asserts the cycle after the counter reaches STARVE_LIM.
  - While stall_req=1, upstream guarantees p_valid=0, so the head pops and the counter clears. stall_req deasserts the following cycle.
  - If p_valid=1 arrives during stall_req anyway, primary still wins and wb_conflict is set.
- chk_pending[i] = 1 when either:
  - chk_addr[i] matches any valid FIFO entry, or
  - wr_en=1 and wr_addr=chk_addr[i].
  - It is combinational from registered state only; same-cycle inputs are excluded.
  - With DROP_R0=1, address 0 never reports pending.
- Ordering contract:
  - Upstream must not issue a primary write to an address that has a pending entry in the FIFO.
  - If p_valid=1 and p_addr matches a valid FIFO entry, wb_conflict is set to 1.
  - wb_conflict stays set until reset.
- Reset mid-operation: queued entries are discarded and no write is issued.

Decomposition:
- Package wb_pkg holds:
  - Default constants: DATA_W, NUM_REGS.
  - Localparam for the starve-counter width: $clog2(STARVE_LIM+1).
- Sub-module wb_fifo: synchronous FIFO with count, pointer wrap, and per-entry valid/address outputs for the parallel compare.
- wb_arbiter contains:
  - selection and the output register,
  - the starve counter,
  - the chk_pending comparators,
  - the conflict flag.

Test Plan:
1. Reset (rstn low, then high) -> wr_en=0, s_ready=1, stall_req=0, wb_conflict=0, chk_pending=0.
2. p_valid, p_addr=5, p_data=0xA5 at cycle n -> wr_en=1, wr_addr=5, wr_data=0xA5 in cycle n+1; chk_pending for addr 5 =1 in cycle n+1 only.
3. p_valid held high; s_valid pushes addrs 1,2,3,4 -> all four accepted, s_ready=0 after 4th; chk_addr={3,9} -> chk_pending={1,0}.
4. STARVE_LIM=3; FIFO holds addr 2, data 0x22; p_valid high 3 cycles -> stall_req=1 next cycle; upstream drops p_valid -> wr_addr=2, wr_data=0x22 written; stall_req=0 after.
5. count=2, simultaneous push (addr 6) and pop -> count stays 2; FIFO order preserved across pointer wrap (addrs emerge 1,2,...,6 in order).
6. FIFO holds addr 7 and p_valid with p_addr=7 -> wb_conflict=1, stays 1 after FIFO drains; then p_valid with p_addr=0 (DROP_R0=1) -> wr_en=0.
